serial_paralelo: RTL and testbench
==================================

Name: serial_paralelo

Overview:
Receive-side counterpart of the 8-bit serializer on the PHY lane. Deserializes the MSB-first serial bit stream on clk_32f and locks byte alignment by hunting for the K28.5 comma (8'hBC) the transmitter sends while idle. After lock, it reconstructs bytes: comma bytes are reported as idle (valid_out low), all other bytes as valid data. Sits between the lane serial input and the receive-side byte logic (byte un-striping, FIFOs).

Parameters:
COMMA, 8'hBC, idle/alignment symbol.
COMMA_LOCK, 4, consecutive aligned commas required to declare lock (legal range 1..15).

Ports:
clk_32f  input  1  bit clock, one serial bit per rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last received non-comma byte
valid_out  output  1  high when data_out was updated at the most recent byte boundary
byte_strobe  output  1  one-cycle pulse at every byte boundary while ACTIVE
active  output  1  high while in ACTIVE (lane aligned)

Behaviour:
- Reset (async, active-high): state=SEARCH, shift reg=0, bit_cnt=0, comma_cnt=0, data_out=8'h00, valid_out=0, byte_strobe=0, active=0. Releasing reset has no further effect on outputs until clock edges arrive.
- Every clk_32f edge: sr <= sr_next, where sr_next = {sr[6:0], data_in}. All compares below use sr_next (the byte including the current bit).
- SEARCH: bit_cnt not used. If sr_next==COMMA: bit_cnt<=0, comma_cnt<=1; go to ACTIVE if COMMA_LOCK==1, otherwise ALIGN. Commas at any bit offset are accepted.
- ALIGN: bit_cnt increments mod 8 each edge. At bit_cnt==7 (byte boundary):
  - if sr_next==COMMA: comma_cnt+1; if that equals COMMA_LOCK go to ACTIVE.
  - else: comma_cnt<=0 and return to SEARCH. The failing byte is not re-searched at other offsets on that edge; search resumes on the next edge.
  - Commas appearing off-boundary in ALIGN are ignored.
- ACTIVE: active=1, registered on the same edge as the state change. This is the edge that completes the last lock comma. bit_cnt continues mod 8 from the alignment found. At bit_cnt==7, on the same edge:
  - byte_strobe<=1
  - if sr_next!=COMMA: data_out<=sr_next, valid_out<=1
  - if sr_next==COMMA: valid_out<=0, data_out holds
  - On all other edges: byte_strobe<=0; valid_out and data_out hold.
- Latency: a byte is visible on data_out on the clk_32f edge that samples its LSB. Outputs are registered, so they are observable in the following cycle.
- Lock is retained in ACTIVE until reset. No loss-of-lock detection in this block.
- The lock edge itself emits no byte_strobe and does not update data_out or valid_out. The first byte_strobe comes 8 edges later.
- A reset asserted mid-byte or mid-lock discards the partial byte and lock immediately. After release the block starts in SEARCH.
- comma_cnt saturates within 4 bits. bit_cnt is 3 bits and wraps naturally.

Decomposition:
- Shared PHY package holds: the K28.5 constant (8'hBC), shared with the serializer, and the state encoding (SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2).
- No sub-module needed. The comma compare and shift register stay inline.
- The same shift-register idiom can be reused later by a loopback checker.

Test Plan:
- Reset: assert reset asynchronously between clock edges -> all outputs 0 immediately; state SEARCH.
- Clean lock: 3 random bits, then 4×8'hBC, then 8'h5A, 8'hBC -> active rises on the edge sampling the LSB of the 4th BC. 8 edges later: byte_strobe pulse, data_out=8'h5A, valid_out=1. Next boundary: byte_strobe pulse, valid_out=0, data_out stays 8'h5A.
- Broken lock: 3×BC then 8'h00, then 4×BC -> active stays 0 through the 8'h00 (back to SEARCH). Active rises only after the 4 further BCs.
- Off-boundary lookalike: send 8'h5E, 8'hF0 (bitstream contains ...10111100... straddling the bytes). Detection in SEARCH is expected. Then supply non-comma on the next boundary -> return to SEARCH, active=0.
- Reset mid-ACTIVE: lock, send half of 8'hA5, assert reset for 1 cycle -> active=0, valid_out=0, data_out=0. Relock required before any strobe.
- COMMA_LOCK=1 build: a single 8'hBC -> active on that edge; next byte 8'h11 -> data_out=8'h11, valid_out=1.

Source files
------------

// File: rtl/serial_paralelo_pkg.sv
// serial_paralelo_pkg
//   Shared PHY lane definitions: the K28.5 comma symbol (also used by the
//   transmit-side serializer) and the receive alignment state encoding.
package serial_paralelo_pkg;

  // K28.5 comma, sent by the transmitter while the lane is idle
  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } phy_state_e;

endpackage

// File: rtl/serial_paralelo.sv
// serial_paralelo
//   Lane deserializer. Shifts in an MSB-first bit stream, hunts for the
//   comma to find byte alignment, and declares lock after COMMA_LOCK
//   consecutive aligned commas. Once locked, it reports every byte boundary
//   with byte_strobe. Non-comma bytes update data_out and set valid_out.
//   Comma bytes clear valid_out and leave data_out unchanged.
// Ports:
//   clk_32f     in   bit clock, one serial bit per rising edge
//   reset       in   async active-high reset
//   data_in     in   serial bit, MSB first
//   data_out    out  [7:0] last received non-comma byte
//   valid_out   out  data_out updated at the most recent byte boundary
//   byte_strobe out  one-cycle pulse per byte boundary while active
//   active      out  lane aligned (lock held until reset)
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter logic [7:0] COMMA      = K28_5,
  parameter int         COMMA_LOCK = 4      // legal 1..15
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [3:0] LOCK_N = 4'(COMMA_LOCK);

  phy_state_e state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] comma_cnt;

  // Compares act on the byte that includes the bit arriving this edge
  logic [7:0] sr_next;
  logic       is_comma;
  logic       boundary;
  logic [3:0] comma_inc;

  assign sr_next   = {sr[6:0], data_in};
  assign is_comma  = (sr_next == COMMA);
  assign boundary  = (bit_cnt == 3'd7);
  assign comma_inc = (comma_cnt == 4'hF) ? 4'hF : comma_cnt + 4'd1;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      comma_cnt   <= 4'd0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr <= sr_next;
      case (state)
        // Accept a comma at any bit offset; the edge that completes it
        // becomes the byte boundary reference (bit_cnt restarts at 0).
        SEARCH: begin
          if (is_comma) begin
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        // Only boundary-aligned commas count; off-boundary ones are ignored.
        // A non-comma boundary byte drops back to SEARCH without rescanning
        // the same byte at other offsets.
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (is_comma) begin
              comma_cnt <= comma_inc;
              if (comma_inc == LOCK_N) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              comma_cnt <= 4'd0;
              state     <= SEARCH;
            end
          end
        end
        // Locked: no loss-of-lock detection, only reset leaves this state
        ACTIVE: begin
          bit_cnt     <= bit_cnt + 3'd1;
          byte_strobe <= boundary;
          if (boundary) begin
            if (is_comma) begin
              valid_out <= 1'b0;
            end else begin
              data_out  <= sr_next;
              valid_out <= 1'b1;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
module tb_serial_paralelo;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out,  data_out1;
  logic       valid_out, valid_out1;
  logic       byte_strobe, byte_strobe1;
  logic       active, active1;

  int total = 0;
  int bad   = 0;

  serial_paralelo dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out),
    .byte_strobe(byte_strobe), .active(active)
  );

  serial_paralelo #(.COMMA_LOCK(1)) dut1 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out1), .valid_out(valid_out1),
    .byte_strobe(byte_strobe1), .active(active1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive on negedge, return 1 time unit after the sampling posedge
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // all bits but the LSB
  task automatic send_msbs(input logic [7:0] b);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
  endtask

  initial begin
    logic any_strobe;
    reset   = 1'b1;
    data_in = 1'b0;
    #3;
    chk("rst_data",   data_out,    8'h00);
    chk("rst_valid",  {7'd0, valid_out},   8'h00);
    chk("rst_strobe", {7'd0, byte_strobe}, 8'h00);
    chk("rst_active", {7'd0, active},      8'h00);
    @(negedge clk_32f);
    reset = 1'b0;

    // ---- clean lock: 3 bits, 4x BC, 5A, BC
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    chk("lock_pre3", {7'd0, active}, 8'h00);
    send_msbs(8'hBC);
    chk("lock_pre4", {7'd0, active}, 8'h00);
    send_bit(1'b0);
    chk("lock_edge",   {7'd0, active},      8'h01);
    chk("lock_nostrb", {7'd0, byte_strobe}, 8'h00);
    chk("lock_noval",  {7'd0, valid_out},   8'h00);
    send_msbs(8'h5A);
    chk("5a_prestrb", {7'd0, byte_strobe}, 8'h00);
    send_bit(1'b0);
    chk("5a_strobe", {7'd0, byte_strobe}, 8'h01);
    chk("5a_data",   data_out,            8'h5A);
    chk("5a_valid",  {7'd0, valid_out},   8'h01);
    send_bit(1'b1);
    chk("5a_strb_drop", {7'd0, byte_strobe}, 8'h00);
    chk("5a_val_hold",  {7'd0, valid_out},   8'h01);
    for (int i = 6; i >= 0; i--) send_bit(8'hBC >> i);
    chk("idle_strobe", {7'd0, byte_strobe}, 8'h01);
    chk("idle_valid",  {7'd0, valid_out},   8'h00);
    chk("idle_data",   data_out,            8'h5A);

    // ---- broken lock: 3x BC, 00, 4x BC
    do_reset();
    chk("brk_rst", {7'd0, active}, 8'h00);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    send_byte(8'h00);
    chk("brk_after00", {7'd0, active}, 8'h00);
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    chk("brk_relock3", {7'd0, active}, 8'h00);
    send_byte(8'hBC);
    chk("brk_relock4", {7'd0, active}, 8'h01);

    // ---- off-boundary comma 5E|F0, found by SEARCH, then non-comma boundary
    do_reset();
    send_byte(8'h5E);
    for (int i = 7; i >= 3; i--) send_bit(8'hF0 >> i);
    chk("off_pre1", {7'd0, active1}, 8'h00);
    send_bit(1'b0);  // completes 10111100
    chk("off_found1", {7'd0, active1}, 8'h01);
    chk("off_act",    {7'd0, active},  8'h00);
    for (int k = 0; k < 8; k++) send_bit(1'b0);  // boundary byte 8'h00
    chk("off_drop", {7'd0, active}, 8'h00);
    // back in SEARCH, so exactly 4 commas lock from here
    for (int k = 0; k < 3; k++) send_byte(8'hBC);
    chk("off_relock3", {7'd0, active}, 8'h00);
    send_byte(8'hBC);
    chk("off_relock4", {7'd0, active}, 8'h01);

    // ---- reset mid-ACTIVE
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    send_byte(8'h5A);
    chk("mid_data_pre", data_out, 8'h5A);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_active", {7'd0, active},    8'h00);
    chk("mid_valid",  {7'd0, valid_out}, 8'h00);
    chk("mid_data",   data_out,          8'h00);
    @(negedge clk_32f);
    reset = 1'b0;
    any_strobe = 1'b0;
    for (int i = 3; i >= 0; i--) begin send_bit(8'hA5 >> i); any_strobe |= byte_strobe | active; end
    for (int i = 7; i >= 0; i--) begin send_bit(8'hA5 >> i); any_strobe |= byte_strobe | active; end
    chk("mid_nolock", {7'd0, any_strobe}, 8'h00);
    for (int k = 0; k < 4; k++) send_byte(8'hBC);
    chk("mid_relock", {7'd0, active}, 8'h01);

    // ---- COMMA_LOCK=1 build
    do_reset();
    send_msbs(8'hBC);
    chk("cl1_pre", {7'd0, active1}, 8'h00);
    send_bit(1'b0);
    chk("cl1_lock", {7'd0, active1}, 8'h01);
    send_byte(8'h11);
    chk("cl1_data",   data_out1,            8'h11);
    chk("cl1_valid",  {7'd0, valid_out1},   8'h01);
    chk("cl1_strobe", {7'd0, byte_strobe1}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
